fir_output_requantizer: RTL and testbench

Consumer end of the FIR lowpass output stream. Takes the 41-bit full-precision accumulator each valid cycle, decimates, rounds and saturates it to 16-bit signed, and buffers results in a small FIFO. The FIFO drains over a valid/ready handshake toward downstream processing and capture.

---
 rtl/fir_output_requantizer_if.sv | 28 ++
 rtl/fir_output_requantizer.sv | 153 +++++++++++++++
 tb/tb_fir_output_requantizer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_output_requantizer_if.sv
// Stream bundle for fir_output_requantizer: accumulator input and FIFO output handshake.
// The slave modport is the requantizer's view; master is the source/sink side.
interface fir_output_requantizer_if #(
    parameter int IN_W  = 41,
    parameter int OUT_W = 16
);
    logic             in_valid;
    logic [IN_W-1:0]  in_data;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );
endinterface

// File: rtl/fir_output_requantizer.sv
// Decimate, round-half-up, saturate a FIR accumulator to OUT_W bits and buffer in a FWFT FIFO.
// Optional macro RQ_STATS_EN enables the saturation/drop statistics counters.
module fir_output_requantizer #(
    parameter int IN_W  = 41,
    parameter int OUT_W = 16,
    parameter int SHIFT = 14,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    fir_output_requantizer_if.slave  s_if,
    input  logic                     i_clr_stat,
    output logic [$clog2(DEPTH):0]   o_fifo_level,
    output logic [15:0]              o_sat_cnt,
    output logic [15:0]              o_drop_cnt
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0]        PH_LAST = PH_W'(DECIM - 1);
    localparam logic [IN_W:0]          RND     = (IN_W+1)'((64'd1 << SHIFT) >> 1);
    localparam logic signed [IN_W:0]   SAT_MAX = (IN_W+1)'((64'd1 << (OUT_W-1)) - 64'd1);
    localparam logic signed [IN_W:0]   SAT_MIN = ~SAT_MAX;

    logic [PH_W-1:0]         r_phase;
    logic                    w_keep;
    logic [IN_W:0]           w_sum;
    logic signed [IN_W:0]    w_shr;
    logic                    w_hi;
    logic                    w_lo;
    logic                    w_sat;
    logic [OUT_W-1:0]        w_q;
    logic                    r_q_valid;
    logic [OUT_W-1:0]        r_q_data;

    assign w_keep = s_if.in_valid && (r_phase == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
        end else if (s_if.in_valid) begin
            r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
        end
    end

    // One guard bit above the input so the rounding offset can never overflow.
    assign w_sum = {s_if.in_data[IN_W-1], s_if.in_data} + RND;
    assign w_shr = $signed(w_sum) >>> SHIFT;
    assign w_hi  = w_shr > SAT_MAX;
    assign w_lo  = w_shr < SAT_MIN;
    assign w_sat = w_keep && (w_hi || w_lo);
    assign w_q   = w_hi ? SAT_MAX[OUT_W-1:0] : (w_lo ? SAT_MIN[OUT_W-1:0] : w_shr[OUT_W-1:0]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q_valid <= 1'b0;
            r_q_data  <= '0;
        end else begin
            r_q_valid <= w_keep;
            if (w_keep) begin
                r_q_data <= w_q;
            end
        end
    end

    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic [OUT_W-1:0] r_out_data;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [AW-1:0]    w_rd_ptr_next;
    logic [AW:0]      w_level_next;

    assign w_pop         = (r_level != '0) && s_if.out_ready;
    assign w_full        = (r_level == (AW+1)'(DEPTH));
    assign w_push        = r_q_valid && (!w_full || w_pop);
    assign w_drop        = r_q_valid && w_full && !w_pop;
    assign w_rd_ptr_next = w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_comb begin
        w_level_next = r_level;
        if (w_push && !w_pop) begin
            w_level_next = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_next = r_level - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_q_data;
        end
    end

    // Head register is the registered RAM read at the next read pointer, with a
    // bypass when that slot is being written this very cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_out_data <= '0;
        end else begin
            r_rd_ptr <= w_rd_ptr_next;
            r_level  <= w_level_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_level_next != '0) begin
                r_out_data <= (w_push && (r_wr_ptr == w_rd_ptr_next)) ? r_q_data
                                                                       : r_mem[w_rd_ptr_next];
            end
        end
    end

    assign s_if.out_valid = (r_level != '0);
    assign s_if.out_data  = r_out_data;
    assign o_fifo_level   = r_level;

`ifdef RQ_STATS_EN
    logic [15:0] r_sat_cnt;
    logic [15:0] r_drop_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sat_cnt  <= '0;
            r_drop_cnt <= '0;
        end else if (i_clr_stat) begin
            r_sat_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_sat && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 1'b1;
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    assign o_sat_cnt  = r_sat_cnt;
    assign o_drop_cnt = r_drop_cnt;
`else
    logic [2:0] w_unused_stats;
    assign w_unused_stats = {i_clr_stat, w_sat, w_drop};
    assign o_sat_cnt      = '0;
    assign o_drop_cnt     = '0;
`endif
endmodule

// File: tb/tb_fir_output_requantizer.sv
// Directed bench for fir_output_requantizer: one DECIM=1 instance and one DECIM=4 instance.
// Statistics expectations follow whether RQ_STATS_EN is defined for the build.
module tb_fir_output_requantizer;
    localparam int IN_W  = 41;
    localparam int OUT_W = 16;
`ifdef RQ_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_d1, clr_d4;
    logic [3:0]  lvl_d1, lvl_d4;
    logic [15:0] sat_d1, drop_d1, sat_d4, drop_d4;

    always #5 clk = ~clk;

    fir_output_requantizer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if_d1 ();
    fir_output_requantizer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) if_d4 ();

    fir_output_requantizer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(14), .DECIM(1), .DEPTH(8)) u_dut_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .s_if(if_d1), .i_clr_stat(clr_d1),
        .o_fifo_level(lvl_d1), .o_sat_cnt(sat_d1), .o_drop_cnt(drop_d1)
    );

    fir_output_requantizer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(14), .DECIM(4), .DEPTH(8)) u_dut_d4 (
        .i_clk(clk), .i_rst_n(rst_n), .s_if(if_d4), .i_clr_stat(clr_d4),
        .o_fifo_level(lvl_d4), .o_sat_cnt(sat_d4), .o_drop_cnt(drop_d4)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_vec++;
        assert (obs === exp) begin
            $display("vec %0d %s observed=%0d expected=%0d ok", n_vec, tag, obs, exp);
        end else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic signed [40:0] rnd_in  [4];
        int                 rnd_exp [4];
        logic signed [40:0] sat_in  [4];
        int                 sat_exp [4];
        int                 drop_ref;

        rnd_in  = '{41'sd8192, 41'sd8191, -41'sd8192, -41'sd8193};
        rnd_exp = '{1, 0, 0, -1};
        sat_in  = '{41'sh0FF_FFFF_FFFF, -41'sh100_0000_0000, 41'sd536862719, 41'sd536862720};
        sat_exp = '{32767, -32768, 32767, 32767};

        rst_n = 1'b0;
        clr_d1 = 1'b0; clr_d4 = 1'b0;
        if_d1.in_valid = 1'b0; if_d1.in_data = '0; if_d1.out_ready = 1'b0;
        if_d4.in_valid = 1'b0; if_d4.in_data = '0; if_d4.out_ready = 1'b0;
        tick(); tick();
        chk("reset_out_valid", if_d4.out_valid, 0);
        chk("reset_out_data", $signed(if_d4.out_data), 0);
        chk("reset_level", lvl_d4, 0);
        chk("reset_sat_cnt", sat_d4, 0);
        chk("reset_drop_cnt", drop_d4, 0);
        rst_n = 1'b1;
        tick();

        // Single kept sample: 100 * 2^14 -> 100, two edges after presentation.
        if_d4.in_valid = 1'b1; if_d4.in_data = 41'd1638400;
        tick();
        if_d4.in_valid = 1'b0;
        chk("lat_one_edge_valid", if_d4.out_valid, 0);
        tick();
        chk("lat_two_edge_valid", if_d4.out_valid, 1);
        chk("lat_data", $signed(if_d4.out_data), 100);
        chk("lat_level", lvl_d4, 1);
        if_d4.out_ready = 1'b1;
        tick();
        if_d4.out_ready = 1'b0;
        chk("pop_empty_valid", if_d4.out_valid, 0);
        chk("pop_empty_level", lvl_d4, 0);

        // Rounding, half toward +inf.
        for (int i = 0; i < 4; i++) begin
            if_d1.in_valid = 1'b1; if_d1.in_data = rnd_in[i];
            tick();
        end
        if_d1.in_valid = 1'b0;
        tick(); tick();
        chk("rnd_level", lvl_d1, 4);
        if_d1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rnd_out%0d", i), $signed(if_d1.out_data), rnd_exp[i]);
            tick();
        end
        if_d1.out_ready = 1'b0;
        chk("rnd_drained_level", lvl_d1, 0);
        chk("empty_hold_data", $signed(if_d1.out_data), -1);

        // Saturation at both rails plus the positive rail boundary.
        for (int i = 0; i < 4; i++) begin
            if_d1.in_valid = 1'b1; if_d1.in_data = sat_in[i];
            tick();
        end
        if_d1.in_valid = 1'b0;
        tick(); tick();
        if_d1.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("sat_out%0d", i), $signed(if_d1.out_data), sat_exp[i]);
            tick();
        end
        if_d1.out_ready = 1'b0;
        chk("sat_cnt", sat_d1, 3 * STATS);
        chk("sat_drop_cnt", drop_d1, 0);
        clr_d1 = 1'b1;
        tick();
        clr_d1 = 1'b0;
        chk("sat_cnt_cleared", sat_d1, 0);

        // Re-align DECIM=4 phase (currently 1) with three discarded samples.
        for (int i = 0; i < 3; i++) begin
            if_d4.in_valid = 1'b1; if_d4.in_data = 41'd999 << 14;
            tick();
        end
        // Decimation with a gap after k=2; kept samples are k=1 and k=5.
        for (int k = 1; k <= 8; k++) begin
            if_d4.in_valid = 1'b1; if_d4.in_data = 41'(k) << 14;
            tick();
            if (k == 2) begin
                if_d4.in_valid = 1'b0;
                tick();
            end
        end
        if_d4.in_valid = 1'b0;
        tick(); tick();
        chk("decim_level", lvl_d4, 2);
        if_d4.out_ready = 1'b1;
        chk("decim_out0", $signed(if_d4.out_data), 1);
        tick();
        chk("decim_out1", $signed(if_d4.out_data), 5);
        tick();
        if_d4.out_ready = 1'b0;
        chk("decim_drained", lvl_d4, 0);

        // Backpressure: 40 inputs, 10 kept, 8 stored, 2 dropped.
        for (int k = 1; k <= 40; k++) begin
            if_d4.in_valid = 1'b1; if_d4.in_data = 41'(k) << 14;
            tick();
        end
        if_d4.in_valid = 1'b0;
        tick(); tick();
        drop_ref = 2 * STATS;
        chk("bp_level", lvl_d4, 8);
        chk("bp_drop_cnt", drop_d4, drop_ref);
        chk("bp_head", $signed(if_d4.out_data), 1);

        // Full FIFO with write and read in the same cycle.
        if_d4.in_valid = 1'b1; if_d4.in_data = 41'd41 << 14;
        tick();
        if_d4.in_valid = 1'b0;
        if_d4.out_ready = 1'b1;
        tick();
        if_d4.out_ready = 1'b0;
        chk("full_rw_level", lvl_d4, 8);
        chk("full_rw_drop_cnt", drop_d4, drop_ref);
        chk("full_rw_head", $signed(if_d4.out_data), 5);

        if_d4.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain_out%0d", i), $signed(if_d4.out_data), 5 + 4 * i);
            tick();
        end
        chk("drain_mid_level", lvl_d4, 4);

        // Asynchronous reset mid-drain, observed before any clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", if_d4.out_valid, 0);
        chk("arst_level", lvl_d4, 0);
        chk("arst_out_data", $signed(if_d4.out_data), 0);
        chk("arst_drop_cnt", drop_d4, 0);
        if_d4.out_ready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_level", lvl_d4, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
